pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Generates per-stage write enables and flushes from load-use hazards, multi-cycle
//  mul/div occupancy, memory wait states and MEM-stage exceptions/ERET.
//  Sits beside the datapath; its outputs drive the stage wr/flush inputs.
// PARAMETERS
//  MUL_LAT  3   cycles a MULT/MULTU occupies the HI/LO unit (>=1)
//  DIV_LAT  33  cycles a DIV/DIVU occupies the HI/LO unit (>=1)
//  CNT_W    6   occupancy counter width; must hold max(MUL_LAT,DIV_LAT)-1
// PORTS
//  clk          in   1  clock
//  rst          in   1  synchronous, active-low reset
//  id_rs        in   5  ID-stage source register rs
//  id_rt        in   5  ID-stage source register rt
//  id_rs_use    in   1  ID instruction reads rs
//  id_rt_use    in   1  ID instruction reads rt
//  id_hilo_use  in   1  ID instruction reads/writes HI/LO (MFHI/MFLO/MTHI/MTLO/MULT/DIV)
//  ex_rd        in   5  EX-stage destination register
//  ex_dmrd      in   1  EX instruction is a load
//  ex_md_start  in   1  EX instruction starts mul/div (one cycle)
//  ex_md_div    in   1  qualifies ex_md_start: 1=divide, 0=multiply
//  if_wait      in   1  instruction fetch not yet returned
//  dm_wait      in   1  data memory access in MEM not yet complete
//  mem_exc      in   1  MEM-stage exception (MEM_Exception)
//  mem_eret     in   1  MEM-stage ERET (MEM_eret_flush)
//  pc_wr        out  1  PC register write enable
//  if_id_wr     out  1  IF/ID write enable
//  id_ex_wr     out  1  ID/EX write enable
//  ex_mem_wr    out  1  EX/MEM write enable
//  mem_wb_wr    out  1  MEM/WB write enable
//  if_flush, id_flush, ex_flush, mem_flush  out 1 each  stage bubble insertion
//  exc_redirect out  1  select exception/EPC vector as NPC this cycle
//  md_busy      out  1  HI/LO unit occupied
// BEHAVIOUR
//  State: FSM {IDLE, MD_BUSY} + down-counter cnt[CNT_W]. Reset: IDLE, cnt=0.
//  While rst=0: every output 0 (enables low, flushes low, md_busy 0).
//  Outputs combinational from state+inputs; priority highest first:
//  1 EXC: (mem_exc|mem_eret)&!dm_wait -> all *_wr=1, all four flushes=1,
//    exc_redirect=1; next state IDLE, cnt=0 (mul/div aborted). dm_wait defers EXC.
//  2 DMWAIT: dm_wait -> all *_wr=0, no flush (whole pipe frozen).
//  3 MDHAZ: md_busy&id_hilo_use -> pc_wr=if_id_wr=0, id_flush=1, others wr=1.
//  4 LOADUSE: ex_dmrd & ex_rd!=0 & ((id_rs_use&id_rs==ex_rd)|(id_rt_use&id_rt==ex_rd))
//    -> pc_wr=if_id_wr=0, id_flush=1, others wr=1.
//  5 IFWAIT: if_wait -> pc_wr=0, if_flush=1 (IF/ID takes bubble), others wr=1.
//  6 RUN: all *_wr=1, no flush.
//  md_busy = (state==MD_BUSY).
//  IDLE->MD_BUSY on ex_md_start&!EXC&!dm_wait: cnt<=(div?DIV_LAT:MUL_LAT)-1.
//    If loaded value is 0, state stays IDLE (single-cycle op, no busy).
//  MD_BUSY: cnt decrements each cycle not in DMWAIT; cnt==0 -> IDLE next cycle.
//  ex_md_start while MD_BUSY cannot occur (MDHAZ blocks it); ignored if it does.
//  Same-cycle EXC and ex_md_start: EXC wins, no load.
//  Reset mid-operation: FSM to IDLE next edge, counter cleared.
// STRUCTURE
//  Shared package/header: stage-state encodings IDLE/MD_BUSY, default latencies.
//  One sub-module natural: md_occupancy (FSM + counter, outputs md_busy).
//  Hazard priority mux stays flat in top.
// TESTING
//  LW $2 in EX, ID reads $2 -> 1 cycle pc_wr=0,if_id_wr=0,id_flush=1; next cycle RUN.
//  Load to $0, ID reads $0 -> no stall.
//  DIV start, MFLO in ID -> md_busy 33 cycles, MDHAZ each; MFLO proceeds cycle 34.
//  mem_exc during MD_BUSY -> all flushes=1, exc_redirect=1, md_busy=0 next cycle.
//  mem_exc with dm_wait=1 for 2 cycles -> frozen 2 cycles, EXC on 3rd.
//  rst=0 during MD_BUSY -> outputs 0, IDLE after release; MULT with MUL_LAT=1 -> no busy.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared encodings, default latencies and helpers for the hazard
//            controller of the 5-stage pipeline.
// Revision : 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int c_MUL_LAT_DFLT = 3;
    localparam int c_DIV_LAT_DFLT = 33;
    localparam int c_CNT_W_DFLT   = 6;

    // A source register collides with a pending load only if it is actually read.
    function automatic logic f_src_hit(
        input logic       i_use,
        input logic [4:0] i_src,
        input logic [4:0] i_dst
    );
        return i_use && (i_src == i_dst);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_md_occupancy
// Brief    : Tracks how long the HI/LO mul/div unit stays occupied.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl_md_occupancy
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = c_MUL_LAT_DFLT,
    parameter int DIV_LAT = c_DIV_LAT_DFLT,
    parameter int CNT_W   = c_CNT_W_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_div,
    input  logic i_exc,
    input  logic i_dm_wait,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_load;

    assign w_load = i_div ? c_DIV_LOAD : c_MUL_LOAD;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // An exception aborts the op; a data-memory wait freezes occupancy with the pipe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_exc) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (!i_dm_wait) begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_cnt_nxt = w_load;
                        if (w_load != '0) begin
                            w_state_nxt = MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_busy = (r_state == MD_BUSY);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Per-stage write-enable/flush sequencer for the 5-stage pipeline.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = c_MUL_LAT_DFLT,
    parameter int DIV_LAT = c_DIV_LAT_DFLT,
    parameter int CNT_W   = c_CNT_W_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_rs_use,
    input  logic       i_id_rt_use,
    input  logic       i_id_hilo_use,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_dmrd,
    input  logic       i_ex_md_start,
    input  logic       i_ex_md_div,
    input  logic       i_if_wait,
    input  logic       i_dm_wait,
    input  logic       i_mem_exc,
    input  logic       i_mem_eret,
    output logic       o_pc_wr,
    output logic       o_if_id_wr,
    output logic       o_id_ex_wr,
    output logic       o_ex_mem_wr,
    output logic       o_mem_wb_wr,
    output logic       o_if_flush,
    output logic       o_id_flush,
    output logic       o_ex_flush,
    output logic       o_mem_flush,
    output logic       o_exc_redirect,
    output logic       o_md_busy
);

    logic w_exc;
    logic w_md_busy;
    logic w_load_use;

    assign w_exc      = (i_mem_exc | i_mem_eret) & ~i_dm_wait;
    assign w_load_use = i_ex_dmrd && (i_ex_rd != 5'd0) &&
                        (f_src_hit(i_id_rs_use, i_id_rs, i_ex_rd) ||
                         f_src_hit(i_id_rt_use, i_id_rt, i_ex_rd));

    pipe_hazard_ctrl_md_occupancy #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_occupancy (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_ex_md_start),
        .i_div     (i_ex_md_div),
        .i_exc     (w_exc),
        .i_dm_wait (i_dm_wait),
        .o_busy    (w_md_busy)
    );

    // State may still read MD_BUSY during the first reset cycle, so gate it.
    assign o_md_busy = rst & w_md_busy;

    always_comb begin
        o_pc_wr        = 1'b0;
        o_if_id_wr     = 1'b0;
        o_id_ex_wr     = 1'b0;
        o_ex_mem_wr    = 1'b0;
        o_mem_wb_wr    = 1'b0;
        o_if_flush     = 1'b0;
        o_id_flush     = 1'b0;
        o_ex_flush     = 1'b0;
        o_mem_flush    = 1'b0;
        o_exc_redirect = 1'b0;
        if (!rst || i_dm_wait) begin
            // whole pipe held (or reset): everything stays low
        end else if (w_exc) begin
            {o_pc_wr, o_if_id_wr, o_id_ex_wr, o_ex_mem_wr, o_mem_wb_wr} = '1;
            {o_if_flush, o_id_flush, o_ex_flush, o_mem_flush}           = '1;
            o_exc_redirect = 1'b1;
        end else if ((w_md_busy && i_id_hilo_use) || w_load_use) begin
            {o_id_ex_wr, o_ex_mem_wr, o_mem_wb_wr} = '1;
            o_id_flush = 1'b1;
        end else if (i_if_wait) begin
            {o_if_id_wr, o_id_ex_wr, o_ex_mem_wr, o_mem_wb_wr} = '1;
            o_if_flush = 1'b1;
        end else begin
            {o_pc_wr, o_if_id_wr, o_id_ex_wr, o_ex_mem_wr, o_mem_wb_wr} = '1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench for pipe_hazard_ctrl (default and short latencies).
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_MUL1 = 3;
    localparam int c_DIV1 = 33;
    localparam int c_MUL2 = 1;
    localparam int c_DIV2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_rs_use, id_rt_use, id_hilo_use;
    logic       ex_dmrd, ex_md_start, ex_md_div;
    logic       if_wait, dm_wait, mem_exc, mem_eret;

    logic pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
    logic if_flush, id_flush, ex_flush, mem_flush, exc_redirect, md_busy;
    logic [9:0] w_dut2_unused;
    logic       md_busy2;

    int n_checks = 0;
    int n_errors = 0;
    int m_left1  = 0;
    int m_left2  = 0;
    int busy_seen;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } sb_entry_t;
    sb_entry_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(c_MUL1), .DIV_LAT(c_DIV1), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rs_use(id_rs_use), .i_id_rt_use(id_rt_use),
        .i_id_hilo_use(id_hilo_use), .i_ex_rd(ex_rd), .i_ex_dmrd(ex_dmrd),
        .i_ex_md_start(ex_md_start), .i_ex_md_div(ex_md_div), .i_if_wait(if_wait),
        .i_dm_wait(dm_wait), .i_mem_exc(mem_exc), .i_mem_eret(mem_eret),
        .o_pc_wr(pc_wr), .o_if_id_wr(if_id_wr), .o_id_ex_wr(id_ex_wr),
        .o_ex_mem_wr(ex_mem_wr), .o_mem_wb_wr(mem_wb_wr), .o_if_flush(if_flush),
        .o_id_flush(id_flush), .o_ex_flush(ex_flush), .o_mem_flush(mem_flush),
        .o_exc_redirect(exc_redirect), .o_md_busy(md_busy)
    );

    pipe_hazard_ctrl #(.MUL_LAT(c_MUL2), .DIV_LAT(c_DIV2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rs_use(id_rs_use), .i_id_rt_use(id_rt_use),
        .i_id_hilo_use(id_hilo_use), .i_ex_rd(ex_rd), .i_ex_dmrd(ex_dmrd),
        .i_ex_md_start(ex_md_start), .i_ex_md_div(ex_md_div), .i_if_wait(if_wait),
        .i_dm_wait(dm_wait), .i_mem_exc(mem_exc), .i_mem_eret(mem_eret),
        .o_pc_wr(w_dut2_unused[0]), .o_if_id_wr(w_dut2_unused[1]), .o_id_ex_wr(w_dut2_unused[2]),
        .o_ex_mem_wr(w_dut2_unused[3]), .o_mem_wb_wr(w_dut2_unused[4]), .o_if_flush(w_dut2_unused[5]),
        .o_id_flush(w_dut2_unused[6]), .o_ex_flush(w_dut2_unused[7]), .o_mem_flush(w_dut2_unused[8]),
        .o_exc_redirect(w_dut2_unused[9]), .o_md_busy(md_busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {pc,ifid,idex,exmem,memwb, if_f,id_f,ex_f,mem_f, redirect, busy, busy2}
    function automatic logic [11:0] model_out();
        logic [11:0] v;
        logic exc, lu, b1, b2;
        exc = (mem_exc | mem_eret) & ~dm_wait;
        b1  = (m_left1 > 0);
        b2  = (m_left2 > 0);
        lu  = ex_dmrd && (ex_rd != 0) &&
              ((id_rs_use && id_rs == ex_rd) || (id_rt_use && id_rt == ex_rd));
        if (!rst)                    v = 12'b00000_0000_0_0_0;
        else if (exc)                v = {5'b11111, 4'b1111, 1'b1, b1, b2};
        else if (dm_wait)            v = {5'b00000, 4'b0000, 1'b0, b1, b2};
        else if ((b1 && id_hilo_use) || lu)
                                     v = {5'b00111, 4'b0100, 1'b0, b1, b2};
        else if (if_wait)            v = {5'b01111, 4'b1000, 1'b0, b1, b2};
        else                         v = {5'b11111, 4'b0000, 1'b0, b1, b2};
        return v;
    endfunction

    function automatic int next_left(input int left, input int mul_lat, input int div_lat);
        int lat;
        if (!rst) return 0;
        if ((mem_exc | mem_eret) && !dm_wait) return 0;
        if (dm_wait) return left;
        if (left > 0) return left - 1;
        if (ex_md_start) begin
            lat = ex_md_div ? div_lat : mul_lat;
            return (lat > 1) ? lat : 0;
        end
        return 0;
    endfunction

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_rs_use = 1'b0; id_rt_use = 1'b0; id_hilo_use = 1'b0;
        ex_dmrd = 1'b0; ex_md_start = 1'b0; ex_md_div = 1'b0;
        if_wait = 1'b0; dm_wait = 1'b0; mem_exc = 1'b0; mem_eret = 1'b0;
    endtask

    // Inputs are set by the caller just after a falling edge.
    task automatic cyc(input string tag);
        sb_entry_t e;
        e.tag = tag;
        e.exp = model_out();
        sb.push_back(e);
        #4;
        e = sb.pop_front();
        check(e.tag, {20'd0, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
                      if_flush, id_flush, ex_flush, mem_flush, exc_redirect, md_busy, md_busy2},
              {20'd0, e.exp});
        if (md_busy === 1'b1) busy_seen++;
        @(posedge clk);
        m_left1 = next_left(m_left1, c_MUL1, c_DIV1);
        m_left2 = next_left(m_left2, c_MUL2, c_DIV2);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        mem_exc = 1'b1; ex_md_start = 1'b1;
        @(negedge clk);
        cyc("reset0");
        cyc("reset1");
        idle_inputs();
        rst = 1'b1;
        cyc("run");

        // load-use on rs, then released
        ex_dmrd = 1'b1; ex_rd = 5'd2; id_rs = 5'd2; id_rs_use = 1'b1;
        cyc("lu_rs");
        check("lu_rs_pc", {31'd0, pc_wr}, 32'd0);
        idle_inputs();
        cyc("lu_after");
        ex_dmrd = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rt_use = 1'b1; id_rs = 5'd7;
        cyc("lu_rt");
        id_rt_use = 1'b0;
        cyc("lu_nouse");
        ex_rd = 5'd0; id_rs = 5'd0; id_rs_use = 1'b1;
        cyc("lu_r0");
        idle_inputs();
        if_wait = 1'b1;
        cyc("ifwait");
        if_wait = 1'b1; ex_dmrd = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_rs_use = 1'b1;
        cyc("lu_over_ifwait");
        idle_inputs();

        // DIV with MFLO waiting in ID
        ex_md_start = 1'b1; ex_md_div = 1'b1; id_hilo_use = 1'b1;
        cyc("div_start");
        ex_md_start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 40 && md_busy !== 1'b0 || i == 0; i++) cyc("div_hold");
        check("div_busy_cycles", busy_seen, 33);
        cyc("div_release");
        idle_inputs();

        // MULT then exception mid-operation
        ex_md_start = 1'b1;
        cyc("mul_start");
        ex_md_start = 1'b0;
        cyc("mul_busy");
        mem_exc = 1'b1;
        cyc("mul_exc");
        mem_exc = 1'b0;
        cyc("mul_aborted");
        check("mul_abort_busy", {31'd0, md_busy}, 32'd0);

        // exception deferred by two data-memory wait cycles
        mem_exc = 1'b1; dm_wait = 1'b1;
        cyc("exc_wait0");
        cyc("exc_wait1");
        dm_wait = 1'b0;
        cyc("exc_taken");
        idle_inputs();
        mem_eret = 1'b1; ex_md_start = 1'b1;
        cyc("eret_vs_start");
        idle_inputs();
        cyc("eret_nostart");

        // DIV stretched by wait states, then reset mid-operation
        ex_md_start = 1'b1; ex_md_div = 1'b1;
        cyc("div2_start");
        idle_inputs();
        cyc("div2_busy");
        dm_wait = 1'b1;
        for (int i = 0; i < 3; i++) cyc("div2_dmwait");
        dm_wait = 1'b0;
        cyc("div2_resume");
        rst = 1'b0; id_hilo_use = 1'b1;
        cyc("div2_rst");
        rst = 1'b1;
        cyc("div2_after_rst");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            id_rs_use = 1'($urandom); id_rt_use = 1'($urandom); id_hilo_use = 1'($urandom);
            ex_dmrd = 1'($urandom);
            ex_md_start = ($urandom_range(0, 7) == 0); ex_md_div = 1'($urandom);
            if_wait = ($urandom_range(0, 3) == 0); dm_wait = ($urandom_range(0, 4) == 0);
            mem_exc = ($urandom_range(0, 30) == 0); mem_eret = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 60) != 0);
            cyc("rand");
        end

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
